// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential request generator with credit-limited
// in-flight tracking and an in-order response queue feeding decode.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_imem_rsp_err,
  output logic        o_insn_valid,
  output logic [31:0] o_insn,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus_4,
  output logic        o_insn_err,
  input  logic        i_insn_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW:0]   LIMIT   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   insn_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic          err_mem  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW-1:0] count_next, outstanding_next;
  logic [31:0]   fetch_pc, rsp_pc;
  logic          active;
  logic [CW:0]   credits_used;
  logic          accept, deq, enq;

  // Queue slots plus in-flight requests share one credit pool so responses never overflow.
  assign credits_used     = {1'b0, count} + {1'b0, outstanding};
  assign o_imem_req_valid = active && (credits_used < LIMIT);
  assign o_imem_req_addr  = fetch_pc;

  assign accept = o_imem_req_valid && i_imem_req_ready;
  assign deq    = o_insn_valid && i_insn_ready;
  assign enq    = i_imem_rsp_valid && (discard == '0) && !i_redirect_valid;

  always_comb begin
    outstanding_next = outstanding;
    if (accept)           outstanding_next = outstanding_next + ONE;
    if (i_imem_rsp_valid) outstanding_next = outstanding_next - ONE;
  end

  always_comb begin
    count_next = count;
    if (enq && !deq)      count_next = count + ONE;
    else if (!enq && deq) count_next = count - ONE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      active      <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      active      <= 1'b1;
      outstanding <= outstanding_next;
      if (i_redirect_valid) begin
        // Everything still in flight after this edge is stale, including this cycle's accept.
        fetch_pc <= i_redirect_pc;
        rsp_pc   <= i_redirect_pc;
        rd_ptr   <= wr_ptr;
        count    <= '0;
        discard  <= outstanding_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (i_imem_rsp_valid) begin
          if (discard != '0) begin
            discard <= discard - ONE;
          end else begin
            wr_ptr <= wr_ptr + PTR_ONE;
            rsp_pc <= rsp_pc + 32'd4;
          end
        end
        if (deq) rd_ptr <= rd_ptr + PTR_ONE;
        count <= count_next;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (enq) begin
      insn_mem[wr_ptr] <= i_imem_rsp_data;
      pc_mem[wr_ptr]   <= rsp_pc;
      err_mem[wr_ptr]  <= i_imem_rsp_err;
    end
  end

  // Head fields read as zero when empty, which also yields the reset values.
  assign o_insn_valid = (count != '0);
  assign o_insn       = o_insn_valid ? insn_mem[rd_ptr] : '0;
  assign o_pc         = o_insn_valid ? pc_mem[rd_ptr] : '0;
  assign o_insn_err   = o_insn_valid && err_mem[rd_ptr];
  assign o_pc_plus_4  = o_pc + 32'd4;

  rsp_without_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_imem_rsp_valid |-> (outstanding != '0));

endmodule
